stage_if: RTL and testbench

Instruction-fetch stage of the five-stage RISC-V pipeline, owning the IF/ID pipeline register that feeds the decode stage its `pc`/`inst` pair. It fetches each 32-bit instruction as four little-endian byte reads over the shared byte-wide memory port and assembles them. It honours the decode stage's branch redirect (`br`/`br_addr`) and the stall bus, and inserts NOP bubbles while no instruction is ready.

---
 rtl/stage_if.sv | 141 ++++++++++++++
 tb/tb_stage_if.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_if.sv
// rtl/stage_if.sv - instruction fetch stage with byte-serial fetch and IF/ID pipeline register
module stage_if #(
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  stall,
   input  logic        br,
   input  logic [31:0] br_addr,
   output logic        if_req,
   output logic [31:0] if_addr,
   input  logic        if_gnt,
   input  logic        if_rvalid,
   input  logic [7:0]  if_rdata,
   output logic [31:0] pc,
   output logic [31:0] inst
);

   typedef enum logic {S_FETCH, S_HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [2:0]  issue_cnt_q, issue_cnt_d;
   logic [2:0]  recv_cnt_q, recv_cnt_d;
   logic [23:0] inst_buf_q, inst_buf_d;
   logic [31:0] hold_inst_q, hold_inst_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic        drop_q, drop_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;

   logic        stall_if;
   logic        grant;
   logic        rx_ok;
   logic [31:0] word;
   logic        unused_stall;

   assign stall_if     = stall[1];
   assign unused_stall = ^{stall[5:2], stall[0]};

   assign if_req  = !reset && (state_q == S_FETCH) && (issue_cnt_q < 3'd4);
   assign if_addr = fetch_pc_q + {29'd0, issue_cnt_q};
   assign grant   = if_req && if_gnt;
   assign rx_ok   = if_rvalid && !drop_q && (recv_cnt_q < issue_cnt_q);
   assign word    = {if_rdata, inst_buf_q};
   assign pc      = pc_q;
   assign inst    = inst_q;

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      issue_cnt_d = issue_cnt_q;
      recv_cnt_d  = recv_cnt_q;
      inst_buf_d  = inst_buf_q;
      hold_inst_d = hold_inst_q;
      hold_pc_d   = hold_pc_q;
      drop_d      = drop_q;
      pc_d        = pc_q;
      inst_d      = inst_q;

      if (if_rvalid && drop_q) begin
         drop_d = 1'b0;
      end

      // Bubble unless something below loads a real instruction
      if (!stall_if) begin
         pc_d   = 32'd0;
         inst_d = NOP_INST;
      end

      if (state_q == S_FETCH) begin
         if (grant) begin
            issue_cnt_d = issue_cnt_q + 3'd1;
         end
         if (rx_ok) begin
            if (recv_cnt_q == 3'd3) begin
               fetch_pc_d  = fetch_pc_q + 32'd4;
               issue_cnt_d = 3'd0;
               recv_cnt_d  = 3'd0;
               if (stall_if) begin
                  hold_inst_d = word;
                  hold_pc_d   = fetch_pc_q;
                  state_d     = S_HOLD;
               end else begin
                  pc_d   = fetch_pc_q;
                  inst_d = word;
               end
            end else begin
               case (recv_cnt_q[1:0])
                  2'd0:    inst_buf_d[7:0]   = if_rdata;
                  2'd1:    inst_buf_d[15:8]  = if_rdata;
                  default: inst_buf_d[23:16] = if_rdata;
               endcase
               recv_cnt_d = recv_cnt_q + 3'd1;
            end
         end
      end else if (!stall_if) begin
         pc_d    = hold_pc_q;
         inst_d  = hold_inst_q;
         state_d = S_FETCH;
      end

      // Redirect wins over any completion or hold transfer in the same cycle
      if (br && !stall_if) begin
         fetch_pc_d  = br_addr;
         issue_cnt_d = 3'd0;
         recv_cnt_d  = 3'd0;
         state_d     = S_FETCH;
         pc_d        = 32'd0;
         inst_d      = NOP_INST;
         drop_d      = grant || (drop_q && !if_rvalid);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_FETCH;
         fetch_pc_q  <= 32'd0;
         issue_cnt_q <= 3'd0;
         recv_cnt_q  <= 3'd0;
         inst_buf_q  <= 24'd0;
         hold_inst_q <= NOP_INST;
         hold_pc_q   <= 32'd0;
         drop_q      <= 1'b0;
         pc_q        <= 32'd0;
         inst_q      <= NOP_INST;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         issue_cnt_q <= issue_cnt_d;
         recv_cnt_q  <= recv_cnt_d;
         inst_buf_q  <= inst_buf_d;
         hold_inst_q <= hold_inst_d;
         hold_pc_q   <= hold_pc_d;
         drop_q      <= drop_d;
         pc_q        <= pc_d;
         inst_q      <= inst_d;
      end
   end

endmodule

// File: tb/tb_stage_if.sv
// tb/tb_stage_if.sv - directed bench for stage_if with a one-cycle-latency byte memory
module tb_stage_if;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  stall;
   logic        br;
   logic [31:0] br_addr;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [7:0]  if_rdata;
   logic [31:0] pc;
   logic [31:0] inst;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   logic [7:0] mem [0:511];

   stage_if #(.NOP_INST(NOP)) dut (
      .clk(clk), .reset(reset), .stall(stall), .br(br), .br_addr(br_addr),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .pc(pc), .inst(inst)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory answers exactly one cycle after each granted request
   task automatic cycle();
      logic        g;
      logic [31:0] a;
      #1;
      g = if_req && if_gnt;
      a = if_addr;
      @(posedge clk);
      #1;
      if_rvalid = g;
      if_rdata  = g ? mem[a[8:0]] : 8'h00;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      stall     = 6'd0;
      br        = 1'b0;
      br_addr   = 32'd0;
      if_gnt    = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = 8'h00;
      #1;
      check("rst_req", {31'd0, if_req}, 32'd0);
      check("rst_inst", inst, NOP);
      check("rst_pc", pc, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      {mem[3], mem[2], mem[1], mem[0]}         = 32'h00500093;
      {mem[7], mem[6], mem[5], mem[4]}         = 32'h00100113;
      {mem[11], mem[10], mem[9], mem[8]}       = 32'haabbccdd;
      {mem[259], mem[258], mem[257], mem[256]} = 32'h123412b7;

      // Basic fetch, grant every cycle
      do_reset();
      if_gnt = 1'b1;
      #1;
      check("t1_req0", {31'd0, if_req}, 32'd1);
      check("t1_addr0", if_addr, 32'd0);
      check("t1_nop0", inst, NOP);
      cycle();
      check("t1_addr1", if_addr, 32'd1);
      check("t1_nop1", inst, NOP);
      cycle();
      check("t1_addr2", if_addr, 32'd2);
      cycle();
      check("t1_addr3", if_addr, 32'd3);
      check("t1_nop3", inst, NOP);
      cycle();
      check("t1_req4", {31'd0, if_req}, 32'd0);
      check("t1_nop4", inst, NOP);
      cycle();
      check("t1_inst5", inst, 32'h00500093);
      check("t1_pc5", pc, 32'd0);
      check("t1_addr5", if_addr, 32'd4);
      run(5);
      check("t1_inst10", inst, 32'h00100113);
      check("t1_pc10", pc, 32'd4);
      cycle();
      check("t1_bubble11", inst, NOP);

      // Grant withheld in cycles 1-2
      do_reset();
      if_gnt = 1'b1;
      cycle();
      if_gnt = 1'b0;
      check("t2_addr1", if_addr, 32'd1);
      cycle();
      check("t2_addr2", if_addr, 32'd1);
      cycle();
      if_gnt = 1'b1;
      check("t2_addr3", if_addr, 32'd1);
      run(3);
      check("t2_nop6", inst, NOP);
      cycle();
      check("t2_inst7", inst, 32'h00500093);

      // Downstream stall cycles 3-7
      do_reset();
      if_gnt = 1'b1;
      run(3);
      stall = 6'b000010;
      run(2);
      check("t3_req5", {31'd0, if_req}, 32'd0);
      check("t3_inst5", inst, NOP);
      run(2);
      check("t3_req7", {31'd0, if_req}, 32'd0);
      cycle();
      stall = 6'd0;
      check("t3_inst8", inst, NOP);
      cycle();
      check("t3_inst9", inst, 32'h00500093);
      check("t3_pc9", pc, 32'd0);
      check("t3_addr9", if_addr, 32'd4);

      // Redirect mid-fetch at pc 8, then an unaligned redirect
      do_reset();
      if_gnt = 1'b1;
      run(10);
      check("t4_addr10", if_addr, 32'd8);
      run(2);
      br      = 1'b1;
      br_addr = 32'h100;
      check("t4_addr12", if_addr, 32'd10);
      cycle();
      br = 1'b0;
      check("t4_inst13", inst, NOP);
      check("t4_pc13", pc, 32'd0);
      check("t4_addr13", if_addr, 32'h100);
      run(5);
      check("t4_inst18", inst, 32'h123412b7);
      check("t4_pc18", pc, 32'h100);
      br      = 1'b1;
      br_addr = 32'h102;
      cycle();
      br = 1'b0;
      check("t4_addr19", if_addr, 32'h102);
      run(5);
      check("t4_inst24", inst, 32'h00001234);
      check("t4_pc24", pc, 32'h102);

      // Redirect ignored under stall
      do_reset();
      if_gnt  = 1'b1;
      stall   = 6'b000010;
      br      = 1'b1;
      br_addr = 32'h200;
      cycle();
      br    = 1'b0;
      stall = 6'd0;
      check("t5_addr1", if_addr, 32'd1);
      check("t5_inst1", inst, NOP);
      run(4);
      check("t5_inst5", inst, 32'h00500093);
      check("t5_pc5", pc, 32'd0);

      // Async reset mid-fetch with a stale response afterwards
      do_reset();
      if_gnt = 1'b1;
      run(10);
      stall = 6'b000010;
      check("t6_pc10", pc, 32'd4);
      run(2);
      check("t6_inst12", inst, 32'h00100113);
      reset = 1'b1;
      #1;
      check("t6_rst_pc", pc, 32'd0);
      check("t6_rst_inst", inst, NOP);
      check("t6_rst_req", {31'd0, if_req}, 32'd0);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      stall     = 6'd0;
      if_rvalid = 1'b1;
      if_rdata  = 8'hff;
      #1;
      check("t6_req0", {31'd0, if_req}, 32'd1);
      check("t6_addr0", if_addr, 32'd0);
      run(5);
      check("t6_inst5", inst, 32'h00500093);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
